// File: rtl/intpol2_pkg.sv
// Shared types and constants for the D4 interpolator feed scheduler.
// State encoding, status bit positions and tap count.
package intpol2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int TAPS = 4;

  localparam int ST_DONE   = 0;
  localparam int ST_BUSY   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_AFULL  = 3;
  localparam int ST_MODE   = 4;
  localparam int ST_BYPASS = 5;

endpackage

// File: rtl/intpol2_valid_pipe.sv
// Delay line carrying calc strobes to the output write strobe.
// any_valid_o ignores the stage being written out this cycle.
module intpol2_valid_pipe #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic calc_i,
  output logic wr_en_o,
  output logic any_valid_o
);

  logic [LAT-1:0] pipe;

  // Shift calc strobes toward the write end
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= calc_i;
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign wr_en_o = pipe[LAT-1];

  // Results still in flight after this cycle's write
  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      any_valid_o = any_valid_o | pipe[i];
    end
  end

endmodule

// File: rtl/intpol2_feed_sched.sv
// Phase accumulator and shift/calc sequencer for the D4 interpolator.
// Handles source back-pressure, output strobes and status.
module intpol2_feed_sched
  import intpol2_pkg::*;
#(
  parameter int FRAC_BITS      = 31,
  parameter int INT_BITS       = 2,
  parameter int MEM_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int CORE_LAT       = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          mode_i,
  input  logic                          bypass_i,
  input  logic                          stop_i,
  input  logic [INT_BITS+FRAC_BITS-1:0] step_i,
  input  logic [CNT_WIDTH-1:0]          num_out_i,
  input  logic                          empty_i,
  input  logic                          afull_i,
  output logic                          fifo_rd_en_o,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_rd_addr_o,
  output logic                          shift_o,
  output logic                          calc_o,
  output logic [FRAC_BITS-1:0]          mu_o,
  output logic                          bypass_o,
  output logic                          wr_en_o,
  output logic [MEM_ADDR_WIDTH-1:0]     wr_addr_o,
  output logic                          done_o,
  output logic [7:0]                    status_o
);

  localparam int STEP_W = INT_BITS + FRAC_BITS;

  state_t state_q, state_d;

  logic                      mode_q;
  logic                      bypass_q;
  logic                      stop_q;
  logic                      done_q;
  logic [STEP_W-1:0]         step_q;
  logic [CNT_WIDTH-1:0]      num_out_q;
  logic [CNT_WIDTH-1:0]      out_cnt_q;
  logic [FRAC_BITS-1:0]      mu_q;
  logic [INT_BITS-1:0]       pending_q;
  logic [1:0]                prime_cnt_q;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr_q;
  logic [MEM_ADDR_WIDTH-1:0] wr_addr_q;

  logic avail;
  logic stop_eff;
  logic limited;
  logic last_out;
  logic launch;
  logic shift;
  logic calc;
  logic stall_empty;
  logic stall_afull;
  logic any_valid;

  assign avail    = ~mode_q | ~empty_i;
  assign stop_eff = mode_q & (stop_i | stop_q);
  assign limited  = ~mode_q | (num_out_q != '0);
  assign last_out = (out_cnt_q + CNT_WIDTH'(1)) == num_out_q;

  // Next state and per-cycle shift/calc decision
  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    shift       = 1'b0;
    calc        = 1'b0;
    stall_empty = 1'b0;
    stall_afull = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          launch = 1'b1;
          if (!mode_i && num_out_i == '0) state_d = S_DRAIN;
          else if (bypass_i)              state_d = S_RUN;
          else                            state_d = S_PRIME;
        end
      end
      S_PRIME: begin
        if (avail) begin
          shift = 1'b1;
          if (prime_cnt_q == 2'(TAPS - 1)) state_d = S_RUN;
        end else begin
          stall_empty = 1'b1;
        end
      end
      S_RUN: begin
        // stop waits only for a shift that can proceed now
        if (bypass_q) begin
          if (stop_eff)     state_d = S_DRAIN;
          else if (!avail)  stall_empty = 1'b1;
          else if (afull_i) stall_afull = 1'b1;
          else begin
            shift = 1'b1;
            calc  = 1'b1;
          end
        end else if (pending_q != '0) begin
          if (avail)         shift = 1'b1;
          else if (stop_eff) state_d = S_DRAIN;
          else               stall_empty = 1'b1;
        end else if (stop_eff) begin
          state_d = S_DRAIN;
        end else if (afull_i) begin
          stall_afull = 1'b1;
        end else begin
          calc = 1'b1;
        end
        if (calc && limited && last_out) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!any_valid) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, run configuration, phase and address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      bypass_q    <= 1'b0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      step_q      <= '0;
      num_out_q   <= '0;
      out_cnt_q   <= '0;
      mu_q        <= '0;
      pending_q   <= '0;
      prime_cnt_q <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        mode_q      <= mode_i;
        bypass_q    <= bypass_i;
        step_q      <= step_i;
        num_out_q   <= num_out_i;
        stop_q      <= 1'b0;
        done_q      <= 1'b0;
        out_cnt_q   <= '0;
        mu_q        <= '0;
        pending_q   <= '0;
        prime_cnt_q <= '0;
        rd_addr_q   <= '0;
        wr_addr_q   <= '0;
      end else begin
        if (state_q != S_IDLE && stop_i) stop_q <= 1'b1;
        if (shift && !mode_q)
          rd_addr_q <= rd_addr_q + MEM_ADDR_WIDTH'(1);
        if (shift && state_q == S_PRIME)
          prime_cnt_q <= prime_cnt_q + 2'd1;
        if (shift && state_q == S_RUN && !bypass_q)
          pending_q <= pending_q - INT_BITS'(1);
        if (calc) begin
          out_cnt_q <= out_cnt_q + CNT_WIDTH'(1);
          if (!bypass_q)
            {pending_q, mu_q} <= {{INT_BITS{1'b0}}, mu_q} + step_q;
        end
        if (wr_en_o) wr_addr_q <= wr_addr_q + MEM_ADDR_WIDTH'(1);
        if (state_q == S_DONE) done_q <= 1'b1;
      end
    end
  end

  intpol2_valid_pipe #(
    .LAT (CORE_LAT)
  ) u_valid_pipe (
    .clk         (clk),
    .rst         (rst),
    .calc_i      (calc),
    .wr_en_o     (wr_en_o),
    .any_valid_o (any_valid)
  );

  assign shift_o       = shift;
  assign calc_o        = calc;
  assign fifo_rd_en_o  = shift & mode_q;
  assign mem_rd_addr_o = rd_addr_q;
  assign mu_o          = mu_q;
  assign bypass_o      = bypass_q;
  assign wr_addr_o     = wr_addr_q;
  assign done_o        = (state_q == S_DONE);

  // Status byte: sticky done, busy, live stalls, latched config
  always_comb begin
    status_o            = '0;
    status_o[ST_DONE]   = done_q | (state_q == S_DONE);
    status_o[ST_BUSY]   = (state_q == S_PRIME) ||
                          (state_q == S_RUN) ||
                          (state_q == S_DRAIN);
    status_o[ST_EMPTY]  = stall_empty;
    status_o[ST_AFULL]  = stall_afull;
    status_o[ST_MODE]   = mode_q;
    status_o[ST_BYPASS] = bypass_q;
  end

endmodule

// File: tb/tb_intpol2_feed_sched.sv
// Bench for intpol2_feed_sched: directed runs plus random runs
// checked cycle by cycle against a count-based reference model.
module tb_intpol2_feed_sched;

  localparam int FRAC = 31;
  localparam int SW   = 33;
  localparam int AW   = 4;
  localparam int CW   = 16;
  localparam int LAT  = 3;
  localparam int TAPS = 4;
  localparam longint unsigned ONE = 64'd1 << FRAC;

  logic clk = 1'b0;
  logic rst;
  logic start_i, mode_i, bypass_i, stop_i;
  logic [SW-1:0] step_i;
  logic [CW-1:0] num_out_i;
  logic empty_i, afull_i;
  logic fifo_rd_en_o;
  logic [AW-1:0] mem_rd_addr_o;
  logic shift_o, calc_o;
  logic [FRAC-1:0] mu_o;
  logic bypass_o, wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic done_o;
  logic [7:0] status_o;

  intpol2_feed_sched dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .mode_i        (mode_i),
    .bypass_i      (bypass_i),
    .stop_i        (stop_i),
    .step_i        (step_i),
    .num_out_i     (num_out_i),
    .empty_i       (empty_i),
    .afull_i       (afull_i),
    .fifo_rd_en_o  (fifo_rd_en_o),
    .mem_rd_addr_o (mem_rd_addr_o),
    .shift_o       (shift_o),
    .calc_o        (calc_o),
    .mu_o          (mu_o),
    .bypass_o      (bypass_o),
    .wr_en_o       (wr_en_o),
    .wr_addr_o     (wr_addr_o),
    .done_o        (done_o),
    .status_o      (status_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit s_done, s_mode, s_byp;
  bit hist [0:4095];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_shift"}, shift_o, 0);
    chk({tag, "_calc"}, calc_o, 0);
    chk({tag, "_fifo_rd"}, fifo_rd_en_o, 0);
    chk({tag, "_rd_addr"}, mem_rd_addr_o, 0);
    chk({tag, "_mu"}, mu_o, 0);
    chk({tag, "_bypass"}, bypass_o, 0);
    chk({tag, "_wr_en"}, wr_en_o, 0);
    chk({tag, "_wr_addr"}, wr_addr_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_status"}, status_o, 0);
  endtask

  // One run: start at cycle 0, model every cycle until the idle
  // cycle after done. abort_at >= 0 asserts rst on that cycle.
  task automatic run(input bit md, input bit by,
                     input longint unsigned stp, input int nout,
                     input int p_e, input int p_a,
                     input int e_burst, input int a_burst,
                     input int src_lim, input int stop_calcs,
                     input int abort_at);
    int  shifts = 0, calcs = 0, writes = 0, k = 0;
    int  done_cyc = 1 << 30, last_calc = -100;
    int  src_left = src_lim, e_left = e_burst, a_left = a_burst;
    int  n_wr = 0, n_sh = 0, n_done = 0;
    bit  e_on = 0, a_on = 0, running = 0, stop_f = 0;
    bit  fin = 0, aborted = 0, need, avail;
    bit  e_shift, e_calc, e_se, e_sa, e_done, e_busy, e_wr;
    logic [7:0]  e_stat;
    logic [63:0] e_mu, e_addr;
    for (int j = 0; j < 4096; j++) hist[j] = 0;
    while (!fin && k < 3000) begin
      @(negedge clk);
      need = running && !by &&
             (shifts < TAPS + int'((longint'(calcs) * stp) >> FRAC));
      start_i   = (k == 0);
      mode_i    = md;
      bypass_i  = by;
      step_i    = stp[SW-1:0];
      num_out_i = nout[CW-1:0];
      if (stop_calcs >= 0 && calcs >= stop_calcs) stop_f = 1;
      if (src_lim >= 0 && src_left == 0 && running) stop_f = 1;
      stop_i = stop_f;
      if (!e_on && e_left > 0 && need && shifts >= TAPS) e_on = 1;
      if (e_on && e_left > 0) begin
        empty_i = 1;
        e_left--;
      end else begin
        empty_i = (src_lim >= 0 && src_left == 0) ||
                  (int'($urandom_range(0, 99)) < p_e);
      end
      if (!a_on && a_left > 0 && running && !need &&
          (by || shifts >= TAPS) && calcs >= 2) a_on = 1;
      if (a_on && a_left > 0) begin
        afull_i = 1;
        a_left--;
      end else begin
        afull_i = int'($urandom_range(0, 99)) < p_a;
      end
      rst = (abort_at == k);
      #1;
      if (abort_at == k) begin
        fin = 1;
        aborted = 1;
      end else begin
        e_shift = 0; e_calc = 0; e_se = 0; e_sa = 0;
        e_done = 0; e_busy = 0; e_mu = 0; e_addr = 0;
        if (k == done_cyc) begin
          e_done = 1;
          s_done = 1;
        end else if (k > done_cyc) begin
          fin = 1;
        end else if (k > 0) begin
          e_busy = 1;
          if (running) begin
            avail = md ? !empty_i : 1'b1;
            if (stop_i && md && (by || shifts >= TAPS) &&
                !(need && avail)) begin
              running = 0;
              done_cyc = ((k + 1 > last_calc + LAT) ?
                          k + 1 : last_calc + LAT) + 1;
            end else if (by) begin
              if (!avail)       e_se = 1;
              else if (afull_i) e_sa = 1;
              else begin
                e_shift = 1;
                e_calc  = 1;
              end
            end else if (need) begin
              if (avail) e_shift = 1;
              else       e_se = 1;
            end else if (afull_i) begin
              e_sa = 1;
            end else begin
              e_calc = 1;
            end
          end
        end
        e_wr = (k >= LAT) && hist[k-LAT];
        e_mu = by ? 0 : ((longint'(calcs) * stp) & (ONE - 1));
        e_addr = shifts % 16;
        e_stat = {2'b00, s_byp, s_mode, e_sa, e_se, e_busy, s_done};
        chk("shift", shift_o, e_shift);
        chk("calc", calc_o, e_calc);
        chk("fifo_rd", fifo_rd_en_o, e_shift & md);
        chk("wr_en", wr_en_o, e_wr);
        chk("done", done_o, e_done);
        chk("status", status_o, e_stat);
        if (e_wr) chk("wr_addr", wr_addr_o, writes % 16);
        if (e_calc) chk("mu", mu_o, e_mu);
        if (e_shift && !md) chk("rd_addr", mem_rd_addr_o, e_addr);
        if (k > 0) chk("bypass_o", bypass_o, by);
        n_wr += int'(wr_en_o);
        n_sh += int'(shift_o);
        n_done += int'(done_o);
        writes += int'(e_wr);
        if (e_shift) begin
          shifts++;
          if (src_left > 0) src_left--;
        end
        if (e_calc) begin
          hist[k] = 1;
          last_calc = k;
          calcs++;
          if ((!md || nout != 0) && calcs == nout) begin
            running = 0;
            done_cyc = k + LAT + 1;
          end
        end
        if (k == 0) begin
          s_done = 0;
          s_mode = md;
          s_byp  = by;
          if (!md && nout == 0) done_cyc = 2;
          else running = 1;
        end
      end
      k++;
    end
    start_i = 0;
    stop_i  = 0;
    afull_i = 0;
    chk("run_ends", fin, 1);
    if (!aborted) begin
      chk("done_pulses", n_done, 1);
      if (!md) chk("n_writes", n_wr, nout);
      if (!md && !by) chk("n_shifts", n_sh, (nout == 0) ? 0 :
        TAPS + int'((longint'(nout - 1) * stp) >> FRAC));
    end
  endtask

  initial begin
    longint unsigned stp;
    bit md, by;
    int nout, stop_c;
    rst = 1; start_i = 0; mode_i = 0; bypass_i = 0; stop_i = 0;
    step_i = '0; num_out_i = '0; empty_i = 0; afull_i = 0;
    s_done = 0; s_mode = 0; s_byp = 0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    rst = 0;

    // memory, step 1.0, 8 outputs, empty_i must be ignored
    run(0, 0, ONE, 8, 50, 0, 0, 0, -1, -1, -1);
    // memory, step 0.25, 8 outputs
    run(0, 0, ONE / 4, 8, 0, 0, 0, 0, -1, -1, -1);
    // stream, 5-cycle empty burst while a shift is pending
    run(1, 0, ONE, 12, 0, 0, 5, 0, -1, -1, -1);
    // memory, 4-cycle afull burst with writes in flight
    run(0, 0, (ONE * 3) / 4, 12, 0, 0, 0, 4, -1, -1, -1);
    // bypass stream, 6 FIFO entries then stop
    run(1, 1, ONE, 0, 0, 0, 0, 0, 6, -1, -1);
    // stream, step 0 until stop
    run(1, 0, 0, 0, 20, 20, 0, 0, -1, 6, -1);

    // reset mid-run, then an empty memory job
    run(0, 0, ONE / 2 + 12345, 20, 30, 20, 0, 0, -1, -1, 15);
    @(negedge clk);
    #1;
    chk_zero("abort");
    rst = 0;
    s_done = 0; s_mode = 0; s_byp = 0;
    run(0, 0, ONE, 0, 0, 0, 0, 0, -1, -1, -1);

    for (int r = 0; r < 10; r++) begin
      md = $urandom_range(0, 1) == 1;
      by = $urandom_range(0, 3) == 0;
      stp = longint'($urandom_range(0, 2)) * ONE +
            longint'($urandom & 32'h7fff_ffff);
      nout = int'($urandom_range(1, 20));
      stop_c = -1;
      if (md && $urandom_range(0, 1) == 1) begin
        nout = 0;
        stop_c = int'($urandom_range(2, 15));
      end
      run(md, by, stp, nout, int'($urandom_range(0, 40)),
          int'($urandom_range(0, 40)), 0, 0, -1, stop_c, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
